altavoz_axil_slave: RTL and testbench
=====================================

# altavoz_axil_slave

AXI4-Lite responder for the altavoz (speaker) peripheral: four 32-bit read/write registers, all read back exactly as written, plus the square-wave tone generator those registers control. It sits behind the block-design AXI interconnect as the S00_AXI target driven by the VIP master. It drives the speaker pin, a busy flag and a level interrupt.

## Interface
- C_S_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: byte address width. addr[3:2] selects the register; addr[1:0] is ignored.
- ACLK  in  1  single clock for the whole block.
- ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR / AWPROT / AWVALID / AWREADY  in/in/in/out  4/3/1/1  write address channel; AWPROT is ignored.
- S_AXI_WDATA / WSTRB / WVALID / WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP / BVALID / BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR / ARPROT / ARVALID / ARREADY  in/in/in/out  4/3/1/1  read address channel; ARPROT is ignored.
- S_AXI_RDATA / RRESP / RVALID / RREADY  out/out/out/in  32/2/1/1  read data channel.
- spk_out  out  1  square-wave output to the speaker.
- busy  out  1  high while a tone is sounding.
- irq  out  1  level interrupt: done AND IRQ_EN.

## Operation
- Register map:
  - 0x0 CTRL: bit0 EN, bit1 MUTE.
  - 0x4 HALF_PERIOD: number of ACLK cycles per output half-period.
  - 0x8 DURATION: number of half-periods to play; 0 plays continuously.
  - 0xC IRQCFG: bit0 IRQ_EN.
- Unused register bits are stored and read back unchanged; they have no hardware effect.
- BRESP and RRESP are always OKAY (2'b00).
- Write path:
  - AW and W are accepted independently, in either order or in the same cycle.
  - Each accepted channel is latched in a holding register.
  - AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
  - When both are held (or both handshake together), the register update is applied, both holding flags are cleared and BVALID is raised.
  - BVALID holds until BREADY is high.
  - Writes are byte-masked: a register byte updates only where its WSTRB bit is 1.
- Read path:
  - ARREADY = !RVALID.
  - On the AR handshake, RDATA is captured from the selected register and RVALID is raised.
  - RVALID and RDATA hold stable until RREADY is high.
- Tone generator:
  - Every completed write to CTRL clears the done flag, zeroes the cycle counter, sets spk_out low and loads remaining = DURATION.
  - If EN=1 after that write, the tone is running.
  - While running and HALF_PERIOD≠0, the counter increments every cycle.
  - When cnt ≥ HALF_PERIOD−1: cnt=0, the internal phase toggles, and remaining decrements if DURATION≠0.
  - When remaining reaches 0 (DURATION≠0): running=0, done=1, phase=0.
  - The ≥ compare lets a smaller HALF_PERIOD written mid-tone take effect at once.
  - HALF_PERIOD=0: no toggling, done never sets.
  - spk_out = phase AND running AND !MUTE. MUTE does not stop the counters.
  - busy = running.
  - Writes to HALF_PERIOD or DURATION while running change the stored value only; DURATION takes effect at the next CTRL write.

## Timing
- Reset values while ARESETN=0:
  - all registers 0, holding flags 0, running 0, done 0;
  - BVALID=0, RVALID=0, RDATA=0, spk_out=0, busy=0, irq=0;
  - AWREADY=WREADY=ARREADY=1.
- Write latency:
  - If the last of AW/W handshakes at edge T, the register holds the new value and BVALID=1 from T+1.
  - The next AW/W is accepted no earlier than the cycle after the B handshake.
  - Best case is one write every 2 cycles.
- Read latency: AR handshake at edge T gives RVALID=1 from T+1. Best case is one read every 2 cycles.
- Read and write to the same register completing at the same edge: the read returns the pre-write value.
- Tone timing:
  - CTRL write with EN=1 at edge T: running=1 from T+1.
  - The first rising spk_out occurs HALF_PERIOD cycles later.
  - done and irq assert in the cycle after the final toggle.
- Reset mid-operation: all state is cleared immediately; any outstanding B/R response is dropped.

## Structure
- altavoz_pkg holds: register offsets (ADDR_CTRL=2'd0 … ADDR_IRQCFG=2'd3), CTRL bit indices, RESP_OKAY, and a typedef for the 32-bit register word.
- altavoz_tone_gen is a sub-module:
  - inputs: restart pulse, EN, MUTE, HALF_PERIOD, DURATION;
  - outputs: spk_out, running, done.
- The AXI channel logic and the register file stay in the top module.

## Test plan
- Write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read back all four -> RDATA 0x1, 0x2, 0x3, 0x4 and every BRESP/RRESP = 00.
- W valid 3 cycles before AW, then AW alone; repeat with AW first -> exactly one BVALID per pair, correct data written, no READY while BVALID is pending.
- Hold BREADY and RREADY low for 5 cycles -> BVALID, RVALID and RDATA stay stable; no new handshake is accepted until the response is taken.
- Write 0xFFFFFFFF to 0x4, then 0x00000012 with WSTRB=0001 -> read back 0xFFFFFF12.
- HALF_PERIOD=3, DURATION=4, IRQCFG=1, CTRL=1 -> spk_out high for 3 cycles, low for 3, twice; then busy=0 and irq=1; a CTRL write of 0 clears irq.
- Tone running with DURATION=0: assert ARESETN=0 for 2 cycles mid-tone -> all outputs and registers read 0 afterwards; set MUTE -> spk_out stays 0 while busy=1.

Source files
------------

// File: rtl/altavoz_pkg.sv
// altavoz_pkg: register map, field indices and byte-strobe merge helper
// shared by the altavoz AXI4-Lite peripheral.
package altavoz_pkg;

    typedef logic [31:0] word_t;

    localparam logic [1:0] ADDR_CTRL        = 2'd0;
    localparam logic [1:0] ADDR_HALF_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_DURATION    = 2'd2;
    localparam logic [1:0] ADDR_IRQCFG      = 2'd3;

    localparam int CTRL_EN   = 0;
    localparam int CTRL_MUTE = 1;
    localparam int IRQCFG_EN = 0;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    function automatic word_t apply_strb(input word_t old_w, input word_t new_w, input logic [3:0] strb);
        word_t r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
        return r;
    endfunction

endpackage

// File: rtl/altavoz_tone_gen.sv
// altavoz_tone_gen: square-wave tone generator; counts HALF_PERIOD cycles per
// half-period and stops after DURATION half-periods (0 = continuous).
module altavoz_tone_gen
    import altavoz_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  restart_i,
    input  logic  en_i,
    input  logic  mute_i,
    input  word_t half_period_i,
    input  word_t duration_i,
    output logic  spk_o,
    output logic  running_o,
    output logic  done_o
);

    logic  running_q, running_d, done_q, done_d, phase_q, phase_d;
    word_t cnt_q, cnt_d, remaining_q, remaining_d;
    logic  active, wrap;

    assign active = running_q && half_period_i != '0;
    // >= rather than == so a shortened HALF_PERIOD applies immediately
    assign wrap   = active && cnt_q >= half_period_i - 32'd1;

    always_comb begin
        running_d   = running_q;
        done_d      = done_q;
        phase_d     = phase_q;
        cnt_d       = cnt_q;
        remaining_d = remaining_q;
        if (restart_i) begin
            running_d   = en_i;
            done_d      = 1'b0;
            phase_d     = 1'b0;
            cnt_d       = '0;
            remaining_d = duration_i;
        end else if (wrap) begin
            cnt_d   = '0;
            phase_d = !phase_q;
            // remaining==0 while running means the tone was started continuous
            if (remaining_q == 32'd1) begin
                running_d   = 1'b0;
                done_d      = 1'b1;
                phase_d     = 1'b0;
                remaining_d = '0;
            end else if (remaining_q != '0) begin
                remaining_d = remaining_q - 32'd1;
            end
        end else if (active) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            running_q   <= 1'b0;
            done_q      <= 1'b0;
            phase_q     <= 1'b0;
            cnt_q       <= '0;
            remaining_q <= '0;
        end else begin
            running_q   <= running_d;
            done_q      <= done_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            remaining_q <= remaining_d;
        end
    end

    assign spk_o     = phase_q && running_q && !mute_i;
    assign running_o = running_q;
    assign done_o    = done_q;

endmodule

// File: rtl/altavoz_axil_slave.sv
// altavoz_axil_slave: AXI4-Lite target with four read/write registers
// controlling the altavoz square-wave tone generator.
module altavoz_axil_slave
    import altavoz_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            spk_out,
    output logic                            busy,
    output logic                            irq
);

    logic       aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic       bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0] awaddr_q, awaddr_d;
    logic [3:0] wstrb_q, wstrb_d;
    word_t      wdata_q, wdata_d, rdata_q, rdata_d;
    word_t      regs_q [4];
    word_t      regs_d [4];

    logic       aw_fire, w_fire, ar_fire, wr_go;
    logic [1:0] wr_addr;
    logic [3:0] wr_strb;
    word_t      wr_data, wr_word;
    logic       done, unused_ok;

    assign S_AXI_AWREADY = !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RDATA   = rdata_q;

    assign aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_fire  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_fire = S_AXI_ARVALID && S_AXI_ARREADY;
    // a held channel is paired with a live handshake on the other one
    assign wr_go   = (aw_held_q || aw_fire) && (w_held_q || w_fire);
    assign wr_addr = aw_held_q ? awaddr_q : S_AXI_AWADDR[3:2];
    assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;
    assign wr_word = apply_strb(regs_q[wr_addr], wr_data, wr_strb);

    always_comb begin
        aw_held_d = !wr_go && (aw_held_q || aw_fire);
        w_held_d  = !wr_go && (w_held_q || w_fire);
        awaddr_d  = aw_fire ? S_AXI_AWADDR[3:2] : awaddr_q;
        wdata_d   = w_fire ? S_AXI_WDATA : wdata_q;
        wstrb_d   = w_fire ? S_AXI_WSTRB : wstrb_q;
        bvalid_d  = wr_go || (bvalid_q && !S_AXI_BREADY);
        rvalid_d  = ar_fire || (rvalid_q && !S_AXI_RREADY);
        rdata_d   = ar_fire ? regs_q[S_AXI_ARADDR[3:2]] : rdata_q;
        for (int i = 0; i < 4; i++) regs_d[i] = regs_q[i];
        if (wr_go) regs_d[wr_addr] = wr_word;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
        end
    end

    // EN comes from the merged write word so the tone starts on the same edge
    altavoz_tone_gen u_tone (
        .clk_i         (ACLK),
        .rst_ni        (ARESETN),
        .restart_i     (wr_go && wr_addr == ADDR_CTRL),
        .en_i          (wr_word[CTRL_EN]),
        .mute_i        (regs_q[ADDR_CTRL][CTRL_MUTE]),
        .half_period_i (regs_q[ADDR_HALF_PERIOD]),
        .duration_i    (regs_q[ADDR_DURATION]),
        .spk_o         (spk_out),
        .running_o     (busy),
        .done_o        (done)
    );

    assign irq       = done && regs_q[ADDR_IRQCFG][IRQCFG_EN];
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_altavoz_axil_slave.sv
// tb_altavoz_axil_slave: table-driven register checks plus directed sequences
// for split writes, response back-pressure, tone timing, reset and mute.
module tb_altavoz_axil_slave;

    logic        ACLK = 1'b0, ARESETN = 1'b0;
    logic [3:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_BREADY = 0, S_AXI_ARVALID = 0, S_AXI_RREADY = 0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic        spk_out, busy, irq;
    int          errors = 0, checks = 0;

    always #5 ACLK = ~ACLK;

    altavoz_axil_slave dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .spk_out(spk_out), .busy(busy), .irq(irq)
    );

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n = 0;
        logic aw_hs, w_hs;
        @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_AWVALID = 1;
        S_AXI_WDATA = data; S_AXI_WSTRB = strb; S_AXI_WVALID = 1;
        while ((S_AXI_AWVALID || S_AXI_WVALID) && n < 20) begin
            aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
            w_hs  = S_AXI_WVALID && S_AXI_WREADY;
            @(negedge ACLK);
            n++;
            if (aw_hs) S_AXI_AWVALID = 0;
            if (w_hs) S_AXI_WVALID = 0;
        end
        while (!S_AXI_BVALID && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        check("write_bvalid", S_AXI_BVALID, 1);
        check("write_bresp", S_AXI_BRESP, 0);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 1;
        @(negedge ACLK);
        S_AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n = 0;
        @(negedge ACLK);
        S_AXI_ARADDR = addr; S_AXI_ARVALID = 1;
        while (!S_AXI_ARREADY && n < 20) begin
            @(negedge ACLK);
            n++;
        end
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        check("read_rvalid", S_AXI_RVALID, 1);
        check("read_rresp", S_AXI_RRESP, 0);
        data = S_AXI_RDATA;
        S_AXI_RREADY = 1;
        @(negedge ACLK);
        S_AXI_RREADY = 0;
    endtask

    task automatic split_write(input logic aw_first, input logic [3:0] addr, input logic [31:0] data);
        @(negedge ACLK);
        S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = 4'hF;
        if (aw_first) S_AXI_AWVALID = 1; else S_AXI_WVALID = 1;
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        repeat (3) begin
            check("split_held_ready", aw_first ? S_AXI_AWREADY : S_AXI_WREADY, 0);
            check("split_other_ready", aw_first ? S_AXI_WREADY : S_AXI_AWREADY, 1);
            check("split_no_bvalid", S_AXI_BVALID, 0);
            @(negedge ACLK);
        end
        if (aw_first) S_AXI_WVALID = 1; else S_AXI_AWVALID = 1;
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        repeat (5) begin
            check("split_bvalid_hold", S_AXI_BVALID, 1);
            check("split_awready_blocked", S_AXI_AWREADY, 0);
            check("split_wready_blocked", S_AXI_WREADY, 0);
            @(negedge ACLK);
        end
        S_AXI_BREADY = 1;
        @(negedge ACLK);
        S_AXI_BREADY = 0;
        check("split_bvalid_single", S_AXI_BVALID, 0);
        check("split_ready_back", {S_AXI_AWREADY, S_AXI_WREADY}, 2'b11);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        vecs[0]  = '{1, 4'h0, 32'h1,        4'hF, 32'h0};
        vecs[1]  = '{1, 4'h4, 32'h2,        4'hF, 32'h0};
        vecs[2]  = '{1, 4'h8, 32'h3,        4'hF, 32'h0};
        vecs[3]  = '{1, 4'hC, 32'h4,        4'hF, 32'h0};
        vecs[4]  = '{0, 4'h0, 32'h0,        4'h0, 32'h1};
        vecs[5]  = '{0, 4'h4, 32'h0,        4'h0, 32'h2};
        vecs[6]  = '{0, 4'h8, 32'h0,        4'h0, 32'h3};
        vecs[7]  = '{0, 4'hC, 32'h0,        4'h0, 32'h4};
        vecs[8]  = '{1, 4'h0, 32'h0,        4'hF, 32'h0};
        vecs[9]  = '{1, 4'h4, 32'hFFFFFFFF, 4'hF, 32'h0};
        vecs[10] = '{1, 4'h4, 32'h12,       4'h1, 32'h0};
        vecs[11] = '{0, 4'h4, 32'h0,        4'h0, 32'hFFFFFF12};
        vecs[12] = '{1, 4'h8, 32'hAABBCCDD, 4'hA, 32'h0};
        vecs[13] = '{0, 4'h8, 32'h0,        4'h0, 32'hAA00CC03};
        vecs[14] = '{0, 4'hD, 32'h0,        4'h0, 32'h4};

        repeat (2) @(negedge ACLK);
        check("rst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        check("rst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("rst_rdata", S_AXI_RDATA, 0);
        check("rst_tone", {spk_out, busy, irq}, 3'b000);
        ARESETN = 1;

        for (int i = 0; i < 15; i++) begin
            if (vecs[i].wr) axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            else begin
                axi_read(vecs[i].addr, rd);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp);
            end
        end

        split_write(0, 4'h4, 32'h55);
        axi_read(4'h4, rd);
        check("split_w_first_data", rd, 32'h55);
        split_write(1, 4'h8, 32'h66);
        axi_read(4'h8, rd);
        check("split_aw_first_data", rd, 32'h66);

        @(negedge ACLK);
        S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1;
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        repeat (5) begin
            check("rstall_rvalid", S_AXI_RVALID, 1);
            check("rstall_rdata", S_AXI_RDATA, 32'h55);
            check("rstall_arready", S_AXI_ARREADY, 0);
            @(negedge ACLK);
        end
        S_AXI_RREADY = 1;
        @(negedge ACLK);
        S_AXI_RREADY = 0;
        check("rstall_released", {S_AXI_RVALID, S_AXI_ARREADY}, 2'b01);

        axi_write(4'h4, 32'd3, 4'hF);
        axi_write(4'h8, 32'd4, 4'hF);
        axi_write(4'hC, 32'd1, 4'hF);
        @(negedge ACLK);
        S_AXI_AWADDR = 4'h0; S_AXI_AWVALID = 1;
        S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1; S_AXI_BREADY = 1;
        @(negedge ACLK);
        S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
        for (int k = 0; k < 16; k++) begin
            check($sformatf("tone_spk_c%0d", k), spk_out, (k >= 3 && k < 6) || (k >= 9 && k < 12));
            check($sformatf("tone_busy_c%0d", k), busy, k < 12);
            check($sformatf("tone_irq_c%0d", k), irq, k >= 12);
            @(negedge ACLK);
            S_AXI_BREADY = 0;
        end
        axi_write(4'h0, 32'h0, 4'hF);
        check("ctrl0_clears_irq", {busy, irq}, 2'b00);

        axi_write(4'h8, 32'd0, 4'hF);
        axi_write(4'h4, 32'd2, 4'hF);
        axi_write(4'h0, 32'd1, 4'hF);
        repeat (5) @(negedge ACLK);
        check("cont_busy", busy, 1);
        S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1;
        @(negedge ACLK);
        S_AXI_ARVALID = 0;
        check("pending_rvalid", S_AXI_RVALID, 1);
        ARESETN = 0;
        #1;
        check("midrst_valid", {S_AXI_BVALID, S_AXI_RVALID}, 2'b00);
        check("midrst_rdata", S_AXI_RDATA, 0);
        check("midrst_tone", {spk_out, busy, irq}, 3'b000);
        check("midrst_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);
        repeat (2) @(negedge ACLK);
        ARESETN = 1;
        for (int a = 0; a < 4; a++) begin
            axi_read(4'(a * 4), rd);
            check($sformatf("postrst_reg%0d", a), rd, 0);
        end
        check("postrst_busy", busy, 0);

        axi_write(4'h4, 32'd2, 4'hF);
        axi_write(4'h0, 32'd3, 4'hF);
        repeat (10) begin
            check("mute_spk", spk_out, 0);
            check("mute_busy", busy, 1);
            @(negedge ACLK);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
